// File: rtl/id_stage_hz.sv
// id_stage_hz -- RISC-V RV32I/RV64I instruction-decode stage.
//
// Decodes the IF/ID instruction, builds its sign-extended immediate, reads the
// register file (with optional same-cycle write-back forwarding), detects
// load-use hazards and registers the result into the ID/EX pipeline register.
//
// Ports
//   clock, reset          rising-edge clock, async active-low reset
//   if_id_*               instruction, PC and valid from IF/ID
//   flush                 kill the instruction being decoded (bubble into ID/EX)
//   wb_regwrite/rd/data   register-file write port from MEM/WB
//   if_id_stall           combinational: hold PC and IF/ID this cycle
//   id_ex_*               registered decode results for EX
module id_stage_hz #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit WB_BYPASS = 1'b1,
  localparam int RA       = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_instruction,
  input  logic [XLEN-1:0] if_id_pc,
  input  logic            flush,
  input  logic            wb_regwrite,
  input  logic [RA-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            if_id_stall,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [RA-1:0]   id_ex_rs1,
  output logic [RA-1:0]   id_ex_rs2,
  output logic [RA-1:0]   id_ex_rd,
  output logic [2:0]      id_ex_funct3,
  output logic            id_ex_funct7b5,
  output logic            id_ex_regwrite,
  output logic            id_ex_memread,
  output logic            id_ex_memwrite,
  output logic            id_ex_memtoreg,
  output logic            id_ex_branch,
  output logic            id_ex_jump,
  output logic            id_ex_alusrc,
  output logic [1:0]      id_ex_aluop,
  output logic            id_ex_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA-1:0]   rs1;
    logic [RA-1:0]   rs2;
    logic [RA-1:0]   rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            branch;
    logic            jump;
    logic            alusrc;
    logic [1:0]      aluop;
    logic            illegal;
  } id_ex_t;

  id_ex_t          id_ex_q, id_ex_d;
  logic [XLEN-1:0] rf_q [NREGS];

  logic [31:0]     ins;
  logic [6:0]      opc;
  logic [RA-1:0]   rs1, rs2, rd;
  logic [31:0]     imm32;
  logic            uses_rs1, uses_rs2, hz, wb_we;
  logic [XLEN-1:0] rs1_data, rs2_data;

  assign ins = if_id_instruction;
  assign opc = ins[6:0];
  // Only the low RA bits of each index field are architectural (NREGS=16 drops bit 4).
  assign rs1 = ins[15 +: RA];
  assign rs2 = ins[20 +: RA];
  assign rd  = ins[7 +: RA];

  // ---------------------------------------------------------------- immediate
  always_comb begin
    imm32 = '0;
    unique case (opc)
      OP_IALU, OP_LOAD, OP_JALR: imm32 = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:                  imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:                 imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:          imm32 = {ins[31:12], 12'b0};
      OP_JAL:                    imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:                   imm32 = '0;
    endcase
  end

  // ---------------------------------------------------------- register read
  assign wb_we = wb_regwrite && (wb_rd != '0);

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != '0) rs1_data = (WB_BYPASS && wb_we && wb_rd == rs1) ? wb_data : rf_q[rs1];
    if (rs2 != '0) rs2_data = (WB_BYPASS && wb_we && wb_rd == rs2) ? wb_data : rf_q[rs2];
  end

  // ------------------------------------------------------------------ hazard
  assign uses_rs1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
  assign uses_rs2 = (opc == OP_R || opc == OP_STORE || opc == OP_BRANCH);

  assign hz = if_id_valid && id_ex_q.valid && id_ex_q.memread && (id_ex_q.rd != '0) &&
              ((id_ex_q.rd == rs1 && uses_rs1) || (id_ex_q.rd == rs2 && uses_rs2));

  // A flush kills the consumer anyway, so there is nothing to hold for.
  assign if_id_stall = hz && !flush;

  // ------------------------------------------------------------------ decode
  always_comb begin
    id_ex_d          = '0;
    id_ex_d.valid    = if_id_valid;
    id_ex_d.pc       = if_id_pc;
    id_ex_d.rs1_data = rs1_data;
    id_ex_d.rs2_data = rs2_data;
    id_ex_d.imm      = XLEN'($signed(imm32));
    id_ex_d.rs1      = rs1;
    id_ex_d.rs2      = rs2;
    id_ex_d.rd       = rd;
    id_ex_d.funct3   = ins[14:12];
    id_ex_d.funct7b5 = ins[30];
    unique case (opc)
      OP_R:      begin id_ex_d.regwrite = 1'b1; id_ex_d.aluop = 2'b10; end
      OP_IALU:   begin id_ex_d.regwrite = 1'b1; id_ex_d.alusrc = 1'b1; id_ex_d.aluop = 2'b11; end
      OP_LOAD:   begin
        id_ex_d.regwrite = 1'b1; id_ex_d.memread = 1'b1;
        id_ex_d.memtoreg = 1'b1; id_ex_d.alusrc  = 1'b1;
      end
      OP_STORE:  begin id_ex_d.memwrite = 1'b1; id_ex_d.alusrc = 1'b1; end
      OP_BRANCH: begin id_ex_d.branch = 1'b1; id_ex_d.aluop = 2'b01; end
      OP_JAL:    begin id_ex_d.regwrite = 1'b1; id_ex_d.jump = 1'b1; end
      OP_JALR:   begin id_ex_d.regwrite = 1'b1; id_ex_d.jump = 1'b1; id_ex_d.alusrc = 1'b1; end
      OP_LUI, OP_AUIPC: begin id_ex_d.regwrite = 1'b1; id_ex_d.alusrc = 1'b1; end
      default:   id_ex_d.illegal = 1'b1;
    endcase
    // An empty slot carries no side effects (and is not an illegal instruction).
    if (!if_id_valid) begin
      id_ex_d.regwrite = 1'b0; id_ex_d.memread = 1'b0; id_ex_d.memwrite = 1'b0;
      id_ex_d.memtoreg = 1'b0; id_ex_d.branch  = 1'b0; id_ex_d.jump     = 1'b0;
      id_ex_d.alusrc   = 1'b0; id_ex_d.aluop   = 2'b00; id_ex_d.illegal  = 1'b0;
    end
  end

  // ------------------------------------------------------------ ID/EX register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           id_ex_q <= '0;
    else if (flush || hz) id_ex_q <= '0;
    else                  id_ex_q <= id_ex_d;
  end

  // ------------------------------------------------------------ register file
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign id_ex_valid    = id_ex_q.valid;
  assign id_ex_pc       = id_ex_q.pc;
  assign id_ex_rs1_data = id_ex_q.rs1_data;
  assign id_ex_rs2_data = id_ex_q.rs2_data;
  assign id_ex_imm      = id_ex_q.imm;
  assign id_ex_rs1      = id_ex_q.rs1;
  assign id_ex_rs2      = id_ex_q.rs2;
  assign id_ex_rd       = id_ex_q.rd;
  assign id_ex_funct3   = id_ex_q.funct3;
  assign id_ex_funct7b5 = id_ex_q.funct7b5;
  assign id_ex_regwrite = id_ex_q.regwrite;
  assign id_ex_memread  = id_ex_q.memread;
  assign id_ex_memwrite = id_ex_q.memwrite;
  assign id_ex_memtoreg = id_ex_q.memtoreg;
  assign id_ex_branch   = id_ex_q.branch;
  assign id_ex_jump     = id_ex_q.jump;
  assign id_ex_alusrc   = id_ex_q.alusrc;
  assign id_ex_aluop    = id_ex_q.aluop;
  assign id_ex_illegal  = id_ex_q.illegal;

endmodule

// File: tb/tb_id_stage_hz.sv
module tb_id_stage_hz;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RA    = $clog2(NREGS);

  logic            clock = 1'b0;
  logic            reset;
  logic            if_id_valid;
  logic [31:0]     if_id_instruction;
  logic [XLEN-1:0] if_id_pc;
  logic            flush;
  logic            wb_regwrite;
  logic [RA-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            if_id_stall;
  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [RA-1:0]   id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [2:0]      id_ex_funct3;
  logic            id_ex_funct7b5, id_ex_regwrite, id_ex_memread, id_ex_memwrite;
  logic            id_ex_memtoreg, id_ex_branch, id_ex_jump, id_ex_alusrc, id_ex_illegal;
  logic [1:0]      id_ex_aluop;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  id_stage_hz #(.XLEN(XLEN), .NREGS(NREGS), .WB_BYPASS(1'b1)) dut (
    .clock(clock), .reset(reset),
    .if_id_valid(if_id_valid), .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
    .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .if_id_stall(if_id_stall), .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_funct3(id_ex_funct3), .id_ex_funct7b5(id_ex_funct7b5),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
    .id_ex_memwrite(id_ex_memwrite), .id_ex_memtoreg(id_ex_memtoreg),
    .id_ex_branch(id_ex_branch), .id_ex_jump(id_ex_jump), .id_ex_alusrc(id_ex_alusrc),
    .id_ex_aluop(id_ex_aluop), .id_ex_illegal(id_ex_illegal)
  );

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, d1, d2, imm;
    logic [RA-1:0]   rs1, rs2, rd;
    logic [2:0]      f3;
    logic            f7;
    logic            rw, mr, mw, mtr, br, jp, as;
    logic [1:0]      aluop;
    logic            ill;
  } exp_t;

  // ---------------------------------------------------------------- model
  logic [XLEN-1:0] mrf [NREGS];
  exp_t            mcur;

  function automatic exp_t act();
    exp_t a;
    a.valid = id_ex_valid; a.pc = id_ex_pc; a.d1 = id_ex_rs1_data; a.d2 = id_ex_rs2_data;
    a.imm = id_ex_imm; a.rs1 = id_ex_rs1; a.rs2 = id_ex_rs2; a.rd = id_ex_rd;
    a.f3 = id_ex_funct3; a.f7 = id_ex_funct7b5; a.rw = id_ex_regwrite; a.mr = id_ex_memread;
    a.mw = id_ex_memwrite; a.mtr = id_ex_memtoreg; a.br = id_ex_branch; a.jp = id_ex_jump;
    a.as = id_ex_alusrc; a.aluop = id_ex_aluop; a.ill = id_ex_illegal;
    return a;
  endfunction

  function automatic string kind_of(input logic [6:0] op);
    case (op)
      7'h33: return "R";     7'h13: return "IALU";  7'h03: return "LOAD";
      7'h23: return "STORE"; 7'h63: return "BRANCH"; 7'h6F: return "JAL";
      7'h67: return "JALR";  7'h37: return "LUI";   7'h17: return "AUIPC";
      default: return "BAD";
    endcase
  endfunction

  function automatic logic [XLEN-1:0] m_read(input int idx, input logic we,
                                              input int wrd, input logic [XLEN-1:0] wd);
    if (idx == 0) return '0;
    if (we && wrd == idx) return wd;
    return mrf[idx];
  endfunction

  function automatic logic m_hz(input exp_t cur, input logic v, input logic [31:0] ins);
    string k = kind_of(ins[6:0]);
    int r1 = int'(ins[19:15]) % NREGS;
    int r2 = int'(ins[24:20]) % NREGS;
    bit u1 = !(k == "LUI" || k == "AUIPC" || k == "JAL");
    bit u2 = (k == "R" || k == "STORE" || k == "BRANCH");
    return v && cur.valid && cur.mr && cur.rd != 0 &&
           ((int'(cur.rd) == r1 && u1) || (int'(cur.rd) == r2 && u2));
  endfunction

  function automatic exp_t m_next(input exp_t cur, input logic v, input logic [31:0] ins,
                                  input logic [XLEN-1:0] pc, input logic fl, input logic we,
                                  input int wrd, input logic [XLEN-1:0] wd);
    exp_t e = '0;
    string k = kind_of(ins[6:0]);
    longint imm = 0;
    if (fl || m_hz(cur, v, ins)) return e;
    e.valid = v; e.pc = pc;
    e.rs1 = RA'(int'(ins[19:15]) % NREGS); e.rs2 = RA'(int'(ins[24:20]) % NREGS);
    e.rd  = RA'(int'(ins[11:7]) % NREGS);
    e.d1 = m_read(int'(e.rs1), we, wrd, wd); e.d2 = m_read(int'(e.rs2), we, wrd, wd);
    e.f3 = ins[14:12]; e.f7 = ins[30];
    if (k == "IALU" || k == "LOAD" || k == "JALR") imm = longint'($signed(ins[31:20]));
    else if (k == "STORE")  imm = longint'($signed({ins[31:25], ins[11:7]}));
    else if (k == "BRANCH") imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    else if (k == "LUI" || k == "AUIPC") imm = longint'($signed(ins[31:12])) * 4096;
    else if (k == "JAL") imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e.imm = imm[XLEN-1:0];
    if (v) begin
      e.rw  = (k != "STORE" && k != "BRANCH" && k != "BAD");
      e.mr  = (k == "LOAD"); e.mtr = (k == "LOAD"); e.mw = (k == "STORE");
      e.br  = (k == "BRANCH"); e.jp = (k == "JAL" || k == "JALR");
      e.as  = (k == "IALU" || k == "LOAD" || k == "STORE" || k == "JALR" || k == "LUI" || k == "AUIPC");
      e.aluop = (k == "R") ? 2'b10 : (k == "IALU") ? 2'b11 : (k == "BRANCH") ? 2'b01 : 2'b00;
      e.ill = (k == "BAD");
    end
    return e;
  endfunction

  // ------------------------------------------------------------- stimulus
  task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                       input logic fl, input logic we, input logic [RA-1:0] wrd,
                       input logic [XLEN-1:0] wd);
    if_id_valid = v; if_id_instruction = ins; if_id_pc = pc; flush = fl;
    wb_regwrite = we; wb_rd = wrd; wb_data = wd;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    n_cmp++; if (act() !== exp_t'(0)) begin n_fail++; $display("FAIL reset_state: got %h want 0", act()); end
    n_cmp++; if (if_id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", if_id_stall); end
  endtask

  task automatic test_itype();
    drive(1'b1, 32'h00500093, XLEN'(32'h100), 1'b0, 1'b0, '0, '0);
    tick();
    n_cmp++;
    if ({id_ex_valid, id_ex_imm, id_ex_rd, id_ex_regwrite, id_ex_alusrc, id_ex_aluop, id_ex_illegal, id_ex_pc} !==
        {1'b1, XLEN'(5), RA'(1), 1'b1, 1'b1, 2'b11, 1'b0, XLEN'(32'h100)}) begin
      n_fail++;
      $display("FAIL itype: got v=%b imm=%h rd=%0d rw=%b as=%b op=%b ill=%b pc=%h", id_ex_valid, id_ex_imm,
               id_ex_rd, id_ex_regwrite, id_ex_alusrc, id_ex_aluop, id_ex_illegal, id_ex_pc);
    end
  endtask

  task automatic test_wb_bypass();
    drive(1'b1, 32'h00018233, '0, 1'b0, 1'b1, RA'(3), XLEN'(32'hDEADBEEF));
    tick();
    n_cmp++; if (id_ex_rs1_data !== XLEN'(32'hDEADBEEF)) begin
      n_fail++; $display("FAIL wb_bypass: got %h want deadbeef", id_ex_rs1_data); end
    drive(1'b1, 32'h00018233, '0, 1'b0, 1'b0, '0, '0);
    tick();
    n_cmp++; if (id_ex_rs1_data !== XLEN'(32'hDEADBEEF)) begin
      n_fail++; $display("FAIL rf_write: got %h want deadbeef", id_ex_rs1_data); end
  endtask

  task automatic test_load_use();
    int stalls = 0;
    drive(1'b1, 32'h0000A283, '0, 1'b0, 1'b0, '0, '0);
    #1; if (if_id_stall) stalls++;
    tick();
    drive(1'b1, 32'h00528333, XLEN'(4), 1'b0, 1'b0, '0, '0);
    #1; if (if_id_stall) stalls++;
    n_cmp++; if (if_id_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", if_id_stall); end
    tick();
    n_cmp++; if (id_ex_valid !== 1'b0 || id_ex_memread !== 1'b0) begin
      n_fail++; $display("FAIL lu_bubble: got v=%b mr=%b want 0 0", id_ex_valid, id_ex_memread); end
    if (if_id_stall) stalls++;
    tick();
    n_cmp++; if ({id_ex_valid, id_ex_regwrite, id_ex_rd} !== {1'b1, 1'b1, RA'(6)}) begin
      n_fail++; $display("FAIL lu_issue: got v=%b rw=%b rd=%0d want 1 1 6", id_ex_valid, id_ex_regwrite, id_ex_rd); end
    n_cmp++; if (stalls != 1) begin n_fail++; $display("FAIL lu_stall_count: got %0d want 1", stalls); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h0000A283, '0, 1'b0, 1'b0, '0, '0);
    tick();
    drive(1'b1, 32'h00528333, '0, 1'b1, 1'b1, RA'(8), XLEN'(32'h1234));
    #1;
    n_cmp++; if (if_id_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", if_id_stall); end
    tick();
    n_cmp++; if (act() !== exp_t'(0)) begin n_fail++; $display("FAIL flush_bubble: got %h want 0", act()); end
    drive(1'b1, 32'h000403B3, '0, 1'b0, 1'b1, RA'(0), XLEN'(32'hFFFF));
    tick();
    n_cmp++; if ({id_ex_rs1_data, id_ex_rs2_data} !== {XLEN'(32'h1234), XLEN'(0)}) begin
      n_fail++; $display("FAIL flush_wb_x0: got rs1=%h rs2=%h want 1234 0", id_ex_rs1_data, id_ex_rs2_data); end
    drive(1'b1, 32'h000003B3, '0, 1'b0, 1'b0, '0, '0);
    tick();
    n_cmp++; if (id_ex_rs1_data !== XLEN'(0)) begin
      n_fail++; $display("FAIL x0_read: got %h want 0", id_ex_rs1_data); end
  endtask

  task automatic test_branch();
    logic signed [XLEN-1:0] m4 = -4;
    drive(1'b1, 32'hFE000EE3, '0, 1'b0, 1'b0, '0, '0);
    tick();
    n_cmp++; if ({id_ex_imm, id_ex_branch, id_ex_aluop, id_ex_regwrite} !== {m4, 1'b1, 2'b01, 1'b0}) begin
      n_fail++; $display("FAIL branch: got imm=%h br=%b op=%b rw=%b", id_ex_imm, id_ex_branch, id_ex_aluop, id_ex_regwrite); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h00500093, '0, 1'b0, 1'b1, RA'(1), XLEN'(32'h55));
    tick();
    idle();
    n_cmp++; if (id_ex_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got %b want 1", id_ex_valid); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (act() !== exp_t'(0)) begin n_fail++; $display("FAIL rst_async: got %h want 0", act()); end
    reset = 1'b1;
    drive(1'b1, 32'h00008133, '0, 1'b0, 1'b0, '0, '0);
    tick();
    n_cmp++; if ({id_ex_valid, id_ex_rs1_data} !== {1'b1, XLEN'(0)}) begin
      n_fail++; $display("FAIL rst_x1: got v=%b rs1=%h want 1 0", id_ex_valid, id_ex_rs1_data); end
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    reset = 1'b0; #1 reset = 1'b1;
    for (int i = 0; i < NREGS; i++) mrf[i] = '0;
    mcur = '0;
    for (int c = 0; c < 400; c++) begin
      logic [31:0] ins = $urandom;
      logic v = ($urandom_range(0, 99) < 85);
      logic fl = ($urandom_range(0, 99) < 8);
      logic we = $urandom_range(0, 1);
      int wrd = $urandom_range(0, 4);
      logic [XLEN-1:0] wd = XLEN'({$urandom, $urandom});
      logic [XLEN-1:0] pc = XLEN'($urandom);
      exp_t e, a;
      ins[6:0] = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      ins[11:7] = 5'($urandom_range(0, 4)); ins[19:15] = 5'($urandom_range(0, 4));
      ins[24:20] = 5'($urandom_range(0, 4));
      drive(v, ins, pc, fl, we, RA'(wrd), wd);
      #1;
      n_cmp++;
      if (if_id_stall !== (m_hz(mcur, v, ins) && !fl)) begin
        n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", c, if_id_stall, m_hz(mcur, v, ins) && !fl);
      end
      e = m_next(mcur, v, ins, pc, fl, we, wrd, wd);
      @(posedge clock);
      if (we && wrd != 0) mrf[wrd] = wd;
      mcur = e;
      #1;
      a = act();
      // An empty slot's illegal flag is not meaningful; only compare it for real instructions.
      if (!v) begin a.ill = 1'b0; e.ill = 1'b0; end
      n_cmp++;
      if (a !== e) begin n_fail++; $display("FAIL rnd_idex c%0d: got %h want %h", c, a, e); end
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b1;
    test_itype();
    test_wb_bypass();
    test_load_use();
    test_flush();
    test_branch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
